// File: rtl/apb_cfg_arbiter.sv
// apb_cfg_arbiter
//   Two-requester round-robin arbiter and APB master sequencer for the
//   configuration register/RAM bus. Requester 0 is the host I2C bridge,
//   requester 1 is the internal config sequencer/scrubber. One transfer is
//   in flight at a time; each runs SETUP then ACCESS, waiting on pready with
//   a timeout, and ends with a one-cycle response strobe to its requester.
//
// Ports
//   clock, reset             single clock, synchronous active-high reset
//   reqN_valid/write/addr/wdata   request from requester N
//   reqN_ready               combinational accept (IDLE only)
//   rspN_valid/rdata/err     registered one-cycle response to requester N
//   psel/penable/pwrite/paddr/pwdata/prdata/pready   APB master side
//   busy                     high whenever the sequencer is not IDLE
//   err_count                saturating count of timed-out transfers
module apb_cfg_arbiter #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_WIDTH       = 8
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  req0_valid,
    input  logic                  req0_write,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_ready,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    output logic                  rsp0_err,

    input  logic                  req1_valid,
    input  logic                  req1_write,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_ready,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,
    output logic                  rsp1_err,

    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,

    output logic                  busy,
    output logic [7:0]            err_count
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                state, state_n;
    logic                  rr_last;   // requester granted most recently
    logic                  gnt;       // requester owning the current transfer
    logic                  gnt_sel;   // requester chosen this cycle in IDLE
    logic                  grant;
    logic [TO_WIDTH-1:0]   to_cnt;
    logic                  to_done;
    logic                  rsp_fire;  // ACCESS completes this cycle
    logic [DATA_WIDTH-1:0] acc_rdata;
    logic                  acc_err;

    // The last permitted wait cycle: ACCESS then spans exactly TIMEOUT_CYCLES.
    assign to_done   = (state == ACCESS) && !pready &&
                       (to_cnt == TO_WIDTH'(TIMEOUT_CYCLES - 1));
    assign rsp_fire  = (state == ACCESS) && (state_n == RESP);
    assign acc_err   = !pready;
    assign acc_rdata = (pready && !pwrite) ? prdata : '0;
    assign busy      = (state != IDLE);

    always_comb begin
        state_n    = state;
        gnt_sel    = 1'b0;
        grant      = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            IDLE: begin
                // On a tie the requester that did not go last wins.
                if (req0_valid && req1_valid) gnt_sel = ~rr_last;
                else                          gnt_sel = req1_valid;
                grant      = req0_valid || req1_valid;
                req0_ready = grant && !gnt_sel;
                req1_ready = grant &&  gnt_sel;
                if (grant) state_n = SETUP;
            end
            SETUP:  state_n = ACCESS;
            ACCESS: if (pready || to_done) state_n = RESP;
            RESP:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            rr_last    <= 1'b1;
            gnt        <= 1'b0;
            to_cnt     <= '0;
            psel       <= 1'b0;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            paddr      <= '0;
            pwdata     <= '0;
            rsp0_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp0_err   <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_rdata <= '0;
            rsp1_err   <= 1'b0;
            err_count  <= '0;
        end else begin
            state   <= state_n;
            // APB strobes are registered off the next state so they line up
            // with the state they belong to.
            psel    <= (state_n == SETUP) || (state_n == ACCESS);
            penable <= (state_n == ACCESS);

            if (state == IDLE && grant) begin
                gnt     <= gnt_sel;
                rr_last <= gnt_sel;
                paddr   <= gnt_sel ? req1_addr  : req0_addr;
                pwrite  <= gnt_sel ? req1_write : req0_write;
                pwdata  <= gnt_sel ? req1_wdata : req0_wdata;
            end

            if (state == SETUP)
                to_cnt <= '0;
            else if (state == ACCESS && !pready && !to_done)
                to_cnt <= to_cnt + 1'b1;

            if (to_done && err_count != 8'hFF)
                err_count <= err_count + 8'd1;

            // Response fields are only non-zero during the strobe cycle, and
            // only on the granted requester's side.
            rsp0_valid <= rsp_fire && !gnt;
            rsp0_rdata <= (rsp_fire && !gnt) ? acc_rdata : '0;
            rsp0_err   <= rsp_fire && !gnt && acc_err;
            rsp1_valid <= rsp_fire && gnt;
            rsp1_rdata <= (rsp_fire && gnt) ? acc_rdata : '0;
            rsp1_err   <= rsp_fire && gnt && acc_err;
        end
    end

endmodule
